// File: rtl/wb_stage.sv
// RV32I writeback stage: captures retiring instructions, runs the data-memory
// load handshake, aligns/extends load data and drives the regfile write port.
package regfilemux;
    typedef enum logic [3:0] {
        alu_out,
        br_en,
        u_imm,
        lw,
        pc_plus4,
        lb,
        lbu,
        lh,
        lhu
    } regfilemux_sel_t;
endpackage

module wb_stage #(
    parameter int unsigned width = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_valid_i,
    input  logic                         WB_load_regfile_i,
    input  logic                         WB_mem_read_i,
    input  regfilemux::regfilemux_sel_t  WB_regfilemux_sel_i,
    input  logic [4:0]                   WB_rd_i,
    input  logic [width-1:0]             WB_alu_out_i,
    input  logic                         WB_br_en_i,
    input  logic [width-1:0]             WB_u_imm_i,
    input  logic [width-1:0]             WB_pc_out_i,
    input  logic                         WB_dmem_resp_i,
    input  logic [width-1:0]             WB_dmem_rdata_i,
    output logic                         WB_dmem_read_o,
    output logic [width-1:0]             WB_dmem_address_o,
    output logic                         WB_load_regfile_o,
    output logic [4:0]                   WB_rd_wr_o,
    output logic [width-1:0]             WB_wr_data_o,
    output logic                         WB_stall_o,
    output logic [CNT_W-1:0]             WB_instret_o
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, COMMIT} state_t;

    state_t                      state;
    logic                        ld_q;
    logic [4:0]                  rd_q;
    regfilemux::regfilemux_sel_t sel_q;
    logic [width-1:0]            alu_q;

    function automatic logic [width-1:0] wb_value(
        input regfilemux::regfilemux_sel_t sel,
        input logic [width-1:0]            alu,
        input logic                        br,
        input logic [width-1:0]            uimm,
        input logic [width-1:0]            pc,
        input logic [width-1:0]            rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{alu[1:0], 3'b000} +: 8];
        // Halfword lane picked by alu[1] only; misaligned offsets are not trapped.
        h = alu[1] ? rdata[31:16] : rdata[15:0];
        case (sel)
            regfilemux::alu_out:  wb_value = alu;
            regfilemux::br_en:    wb_value = {{(width-1){1'b0}}, br};
            regfilemux::u_imm:    wb_value = uimm;
            regfilemux::pc_plus4: wb_value = pc + width'(4);
            regfilemux::lw:       wb_value = rdata;
            regfilemux::lb:       wb_value = {{(width-8){b[7]}}, b};
            regfilemux::lbu:      wb_value = {{(width-8){1'b0}}, b};
            regfilemux::lh:       wb_value = {{(width-16){h[15]}}, h};
            regfilemux::lhu:      wb_value = {{(width-16){1'b0}}, h};
            default:              wb_value = alu;
        endcase
    endfunction

    // Stall and the read request are combinational so upstream freezes in the
    // same cycle the stage enters MEM_WAIT, including the response cycle.
    assign WB_stall_o        = (state == MEM_WAIT);
    assign WB_dmem_read_o    = (state == MEM_WAIT);
    assign WB_dmem_address_o = {alu_q[width-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            ld_q              <= 1'b0;
            rd_q              <= '0;
            sel_q             <= regfilemux::alu_out;
            alu_q             <= '0;
            WB_load_regfile_o <= 1'b0;
            WB_rd_wr_o        <= '0;
            WB_wr_data_o      <= '0;
            WB_instret_o      <= '0;
        end else begin
            WB_load_regfile_o <= 1'b0;
            if (state == COMMIT) begin
                WB_instret_o <= WB_instret_o + CNT_W'(1);
            end
            case (state)
                IDLE, COMMIT: begin
                    if (WB_valid_i) begin
                        ld_q  <= WB_load_regfile_i;
                        rd_q  <= WB_rd_i;
                        sel_q <= WB_regfilemux_sel_i;
                        alu_q <= WB_alu_out_i;
                        if (WB_mem_read_i) begin
                            state <= MEM_WAIT;
                        end else begin
                            state             <= COMMIT;
                            WB_load_regfile_o <= WB_load_regfile_i && (WB_rd_i != 5'd0);
                            WB_rd_wr_o        <= WB_rd_i;
                            WB_wr_data_o      <= wb_value(WB_regfilemux_sel_i, WB_alu_out_i,
                                                          WB_br_en_i, WB_u_imm_i,
                                                          WB_pc_out_i, WB_dmem_rdata_i);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (WB_dmem_resp_i) begin
                        state             <= COMMIT;
                        WB_load_regfile_o <= ld_q && (rd_q != 5'd0);
                        WB_rd_wr_o        <= rd_q;
                        WB_wr_data_o      <= wb_value(sel_q, alu_q, 1'b0, '0, '0,
                                                      WB_dmem_rdata_i);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
